tetris_parca_sirala: RTL
========================

// Module: tetris_parca_sirala
// PURPOSE
//   Piece sequencer/controller in front of the tetris core. Buffers incoming piece
//   codes in a small FIFO and issues them to the core's parca input one per slot.
//   Inserts PARCA_YOK (3'b000) gap cycles between pieces. Halts on game over
//   (core bitti_mi, or height limit).
// PARAMETERS
//   DERINLIK  4   FIFO depth in entries; power of two, >=2
//   BOSLUK    1   PARCA_YOK cycles driven after each issued piece; 0 = back-to-back
//   SINIR     20  yukseklik value at or above which play stops
//   SAYAC_W   8   width of issued-piece counter
// PORTS
//   clk            in   1        system clock, rising edge
//   rst            in   1        asynchronous, active-high reset
//   baslat         in   1        start pulse; honoured only in BOSTA
//   parca_gir      in   3        incoming piece code
//   parca_gecerli  in   1        parca_gir valid
//   parca_hazir    out  1        sequencer can accept; transfer = gecerli & hazir
//   parca          out  3        registered piece code to tetris core
//   bitti_mi       in   1        game-over flag from core
//   yukseklik      in   5        stack height from core
//   durum          out  2        00 BOSTA, 01 CALIS, 10 BOSLUK, 11 DUR
//   verilen        out  SAYAC_W  pieces issued since reset; saturates at all-ones
//   oyun_bitti     out  1        high in DUR
// BEHAVIOUR
//   Reset (async, immediate): state BOSTA, parca=000, verilen=0, oyun_bitti=0,
//     FIFO empty, gap counter 0. parca_hazir = !dolu && state!=DUR, so it is 1
//     after reset.
//   Push: on transfer with parca_gir!=000, enqueue. A 000 code completes the
//     handshake but is discarded. No push when full (hazir=0). No full bypass.
//   stop = bitti_mi | (yukseklik >= SINIR), unsigned 5-bit compare, sampled each
//     cycle in CALIS/BOSLUK.
//   BOSTA: parca<=000; FIFO still accepts pushes; baslat -> CALIS.
//   CALIS: stop -> DUR (stop wins over pop, no pop that cycle).
//     Else if FIFO non-empty: parca<=head, pop, verilen++;
//       -> BOSLUK with gap counter=BOSLUK (stay CALIS if BOSLUK==0).
//     Else parca<=000, stay.
//   BOSLUK: parca<=000, counter--.
//     When counter reaches 1 on entry cycle count -> CALIS (exactly BOSLUK cycles
//     of 000 on parca). stop -> DUR.
//   DUR: parca<=000, oyun_bitti=1, hazir=0, FIFO contents held, no pops.
//     baslat ignored. Exit only via rst.
//   baslat outside BOSTA ignored. Push and pop in the same cycle both take effect;
//     count unchanged.
//   Latency: piece enqueued at edge N into empty FIFO while in CALIS appears on
//     parca after edge N+1, held exactly 1 cycle.
//   Piece already on parca when stop rises is not recalled.
//   durum/oyun_bitti are decoded from registered state, so they are glitch-free.
// STRUCTURE
//   tetris_pkg: PARCA_W=3, YUKSEKLIK_W=5, PARCA_YOK=3'b000, state localparams
//     BOSTA/CALIS/BOSLUK/DUR (2-bit).
//   Sub-module tetris_parca_fifo (DERINLIK, width PARCA_W): push/pop, head,
//     bos/dolu flags, pointer wrap modulo DERINLIK, extra pointer bit for full.
//   Top holds FSM, gap counter ($clog2(BOSLUK+1) bits, min 1), verilen counter.
// TESTING
//   1 rst, baslat, push 101 -> parca=101 one cycle, then 000 for 1 cycle;
//     verilen=1, durum 01->10->01.
//   2 push 101,011,110 back-to-back (BOSLUK=1) -> parca 101,000,011,000,110,000;
//     verilen=3.
//   3 in BOSTA push 4 codes -> hazir=0 after 4th, 5th stalls;
//     baslat -> hazir=1 after first pop, order preserved.
//   4 bitti_mi=1 with 2 queued -> next cycle durum=11, oyun_bitti=1, parca=000,
//     verilen frozen, hazir=0; baslat has no effect.
//   5 yukseklik=19 -> play continues; yukseklik=20 -> DUR.
//     Push 000 -> handshake ok, FIFO count unchanged.
//   6 rst asserted mid-BOSLUK -> parca=000, verilen=0, durum=00 immediately,
//     without waiting for a clock edge.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared widths, the empty-piece code and FSM state encodings for the
// tetris piece sequencer.
package tetris_pkg;
  localparam int PARCA_W     = 3;
  localparam int YUKSEKLIK_W = 5;

  localparam logic [PARCA_W-1:0] PARCA_YOK = 3'b000;

  localparam logic [1:0] BOSTA  = 2'b00;
  localparam logic [1:0] CALIS  = 2'b01;
  localparam logic [1:0] BOSLUK = 2'b10;
  localparam logic [1:0] DUR    = 2'b11;
endpackage

// File: rtl/tetris_parca_sirala_if.sv
// Valid/ready handshake carrying piece codes into the sequencer.
interface tetris_parca_sirala_if;
  import tetris_pkg::*;

  logic [PARCA_W-1:0] parca_gir;
  logic               parca_gecerli;
  logic               parca_hazir;

  modport master (output parca_gir, output parca_gecerli, input parca_hazir);
  modport slave  (input parca_gir, input parca_gecerli, output parca_hazir);
endinterface

// File: rtl/tetris_parca_fifo.sv
// Small piece FIFO with combinational head; an extra pointer bit
// distinguishes full from empty.
module tetris_parca_fifo #(
  parameter int DERINLIK = 4,
  parameter int W        = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] veri,
  output logic [W-1:0] bas,
  output logic         bos,
  output logic         dolu
);
  localparam int AW = $clog2(DERINLIK);

  logic [AW:0]  yaz_reg;
  logic [AW:0]  oku_reg;
  logic [W-1:0] mem [DERINLIK];
  logic         push_ok;
  logic         pop_ok;

  assign bos     = (yaz_reg == oku_reg);
  assign dolu    = (yaz_reg[AW] != oku_reg[AW]) &&
                   (yaz_reg[AW-1:0] == oku_reg[AW-1:0]);
  assign push_ok = push && !dolu;
  assign pop_ok  = pop && !bos;
  assign bas     = mem[oku_reg[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      yaz_reg <= '0;
      oku_reg <= '0;
    end else begin
      if (push_ok) yaz_reg <= yaz_reg + 1'b1;
      if (pop_ok)  oku_reg <= oku_reg + 1'b1;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[yaz_reg[AW-1:0]] <= veri;
  end
endmodule

// File: rtl/tetris_parca_sirala.sv
// Piece sequencer: queues incoming codes and issues one per slot to the
// tetris core, with PARCA_YOK gaps, halting for good on game over.
module tetris_parca_sirala
  import tetris_pkg::*;
#(
  parameter int          DERINLIK = 4,
  parameter int          BOSLUK   = 1,
  parameter int unsigned SINIR    = 20,
  parameter int          SAYAC_W  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   baslat,
  tetris_parca_sirala_if.slave   giris,
  output logic [PARCA_W-1:0]     parca,
  input  logic                   bitti_mi,
  input  logic [YUKSEKLIK_W-1:0] yukseklik,
  output logic [1:0]             durum,
  output logic [SAYAC_W-1:0]     verilen,
  output logic                   oyun_bitti
);
  localparam int GAP_W = (BOSLUK < 1) ? 1 : $clog2(BOSLUK + 1);
  localparam logic [GAP_W-1:0] GAP_YUK = GAP_W'(BOSLUK);

  logic [1:0]         durum_reg, durum_next;
  logic [PARCA_W-1:0] parca_reg, parca_next;
  logic [SAYAC_W-1:0] verilen_reg, verilen_next;
  logic [GAP_W-1:0]   sayac_reg, sayac_next;
  logic [PARCA_W-1:0] bas;
  logic               bos, dolu, push, pop, dur;

  assign giris.parca_hazir = !dolu && (durum_reg != DUR);
  assign push = giris.parca_gecerli && giris.parca_hazir && (giris.parca_gir != PARCA_YOK);
  assign dur  = bitti_mi || (32'(yukseklik) >= SINIR);

  tetris_parca_fifo #(.DERINLIK(DERINLIK), .W(PARCA_W)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .veri (giris.parca_gir),
    .bas  (bas),
    .bos  (bos),
    .dolu (dolu)
  );

  // The state constant BOSLUK is shadowed by the gap-length parameter, hence the qualified name.
  always_comb begin
    durum_next   = durum_reg;
    parca_next   = PARCA_YOK;
    verilen_next = verilen_reg;
    sayac_next   = sayac_reg;
    pop          = 1'b0;
    case (durum_reg)
      BOSTA: begin
        if (baslat) durum_next = CALIS;
      end
      CALIS: begin
        if (dur) begin
          durum_next = DUR;
        end else if (!bos) begin
          parca_next = bas;
          pop        = 1'b1;
          if (verilen_reg != '1) verilen_next = verilen_reg + 1'b1;
          if (BOSLUK != 0) begin
            durum_next = tetris_pkg::BOSLUK;
            sayac_next = GAP_YUK;
          end
        end
      end
      tetris_pkg::BOSLUK: begin
        if (dur) begin
          durum_next = DUR;
        end else begin
          sayac_next = sayac_reg - 1'b1;
          if (sayac_reg <= 1) durum_next = CALIS;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_reg   <= BOSTA;
      parca_reg   <= PARCA_YOK;
      verilen_reg <= '0;
      sayac_reg   <= '0;
    end else begin
      durum_reg   <= durum_next;
      parca_reg   <= parca_next;
      verilen_reg <= verilen_next;
      sayac_reg   <= sayac_next;
    end
  end

  assign parca      = parca_reg;
  assign durum      = durum_reg;
  assign verilen    = verilen_reg;
  assign oyun_bitti = (durum_reg == DUR);
endmodule
